// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: per-source edge detect, IDLE/PEND/ACTIVE tracking,
// enable masking and claim/complete handshake. Optional IRQ_CTRL_SYNC_EN adds 2-flop input synchronizers.
module irq_ctrl #(
  parameter int NSRC = 4,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            en_wr,
  input  logic [NSRC-1:0] en_wdata,
  output logic [NSRC-1:0] en_mask,
  input  logic            claim_req,
  output logic            claim_ack,
  output logic [IDW-1:0]  claim_id,
  input  logic            cmpl_valid,
  input  logic [IDW-1:0]  cmpl_id,
  output logic [NSRC-1:0] pend,
  output logic            irq_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  logic [NSRC-1:0] w_src;
  logic [NSRC-1:0] r_prev;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] r_en_mask;
  logic [NSRC-1:0] r_repend;
  logic [NSRC-1:0] w_repend_nxt;
  logic [NSRC-1:0] w_pend;
  logic [NSRC-1:0] w_cand;
  logic [NSRC-1:0] w_claim_hit;
  logic [NSRC-1:0] w_cmpl_hit;
  state_t          r_state     [NSRC];
  state_t          w_state_nxt [NSRC];
  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic            r_claim_ack;
  logic [IDW-1:0]  r_claim_id;
  logic            r_irq;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;

  // two-flop synchronizer for sources from foreign clock domains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = src_irq;
`endif

  assign w_edge = w_src & ~r_prev;
  assign w_cand = w_pend & r_en_mask;

  // lowest index wins: scan downward so the last hit is the lowest candidate
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      w_found = w_found | w_cand[i];
      w_idx   = w_cand[i] ? IDW'(i) : w_idx;
    end
  end

  // per-source decode of the claim winner and the completion target
  always_comb begin
    w_claim_hit = '0;
    w_cmpl_hit  = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_claim_hit[i] = claim_req & w_found & (w_idx == IDW'(i));
      w_cmpl_hit[i]  = cmpl_valid & (cmpl_id == IDW'(i + 1));
    end
  end

  // per-source state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        r_state[i] <= S_IDLE;
      end
      r_repend <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
      r_repend <= w_repend_nxt;
    end
  end

  // per-source next-state logic
  always_comb begin
    w_repend_nxt = r_repend;
    for (int i = 0; i < NSRC; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE: begin
          w_state_nxt[i] = w_edge[i] ? S_PEND : S_IDLE;
        end
        S_PEND: begin
          if (w_claim_hit[i]) begin
            w_state_nxt[i]  = S_ACTIVE;
            w_repend_nxt[i] = w_edge[i];
          end else begin
            w_state_nxt[i] = S_PEND;
          end
        end
        S_ACTIVE: begin
          if (w_cmpl_hit[i]) begin
            w_state_nxt[i]  = (r_repend[i] | w_edge[i]) ? S_PEND : S_IDLE;
            w_repend_nxt[i] = 1'b0;
          end else begin
            w_state_nxt[i]  = S_ACTIVE;
            w_repend_nxt[i] = r_repend[i] | w_edge[i];
          end
        end
        default: begin
          w_state_nxt[i]  = S_IDLE;
          w_repend_nxt[i] = 1'b0;
        end
      endcase
    end
  end

  // state decode for the pending view
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_pend[i] = (r_state[i] == S_PEND);
    end
  end

  // edge history, enable mask and registered handshake/interrupt outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_en_mask   <= '0;
      r_claim_ack <= 1'b0;
      r_claim_id  <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_prev      <= w_src;
      r_en_mask   <= en_wr ? en_wdata : r_en_mask;
      r_claim_ack <= claim_req;
      r_claim_id  <= (claim_req & w_found) ? (w_idx + IDW'(1)) : '0;
      r_irq       <= |w_cand;
    end
  end

  assign en_mask   = r_en_mask;
  assign pend      = w_pend;
  assign claim_ack = r_claim_ack;
  assign claim_id  = r_claim_id;
  assign irq_out   = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl (default build, NSRC=4, IDW=3).
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src_irq;
  logic       en_wr;
  logic [3:0] en_wdata;
  logic [3:0] en_mask;
  logic       claim_req;
  logic       claim_ack;
  logic [2:0] claim_id;
  logic       cmpl_valid;
  logic [2:0] cmpl_id;
  logic [3:0] pend;
  logic       irq_out;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NSRC(4), .IDW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .en_wr      (en_wr),
    .en_wdata   (en_wdata),
    .en_mask    (en_mask),
    .claim_req  (claim_req),
    .claim_ack  (claim_ack),
    .claim_id   (claim_id),
    .cmpl_valid (cmpl_valid),
    .cmpl_id    (cmpl_id),
    .pend       (pend),
    .irq_out    (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic       wr;
    logic [3:0] wdata;
    logic       claim;
    logic       cv;
    logic [2:0] cid;
    logic [3:0] e_pend;
    logic       e_irq;
    logic       e_ack;
    logic [2:0] e_id;
    logic [3:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] src, input logic wr, input logic [3:0] wdata,
                     input logic claim, input logic cv, input logic [2:0] cid,
                     input logic [3:0] e_pend, input logic e_irq, input logic e_ack,
                     input logic [2:0] e_id, input logic [3:0] e_mask);
    vec_t v;
    v.src = src; v.wr = wr; v.wdata = wdata; v.claim = claim; v.cv = cv; v.cid = cid;
    v.e_pend = e_pend; v.e_irq = e_irq; v.e_ack = e_ack; v.e_id = e_id; v.e_mask = e_mask;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {pend, irq_out, claim_ack, claim_id, en_mask}
  function automatic logic [31:0] outs();
    return {19'd0, pend, irq_out, claim_ack, claim_id, en_mask};
  endfunction

  function automatic logic [31:0] pack(input logic [3:0] p, input logic i, input logic a,
                                       input logic [2:0] id, input logic [3:0] m);
    return {19'd0, p, i, a, id, m};
  endfunction

  // one clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic cyc(input logic [3:0] src, input logic wr, input logic [3:0] wdata,
                     input logic claim, input logic cv, input logic [2:0] cid);
    @(negedge clk);
    src_irq = src; en_wr = wr; en_wdata = wdata;
    claim_req = claim; cmpl_valid = cv; cmpl_id = cid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; src_irq = 4'd0; en_wr = 1'b0; en_wdata = 4'd0;
    claim_req = 1'b0; cmpl_valid = 1'b0; cmpl_id = 3'd0;

    //    src      wr    wdata    clm   cv    cid     pend     irq   ack   id      mask
    // single source, claim, complete
    add(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd1, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0001);
    // priority between src 1 and src 2
    add(4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0110);
    add(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0110, 1'b0, 1'b0, 3'd0, 4'b0110);
    add(4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b1, 1'b1, 3'd2, 4'b0110);
    add(4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd3, 4'b0110);
    add(4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0110);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0110);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd3, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0110);
    // disabled source still pends; enabling raises irq two cycles after en_wr
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1000, 1'b0, 1'b0, 3'd0, 4'b0000);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1000, 1'b0, 1'b0, 3'd0, 4'b0000);
    add(4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 3'd0, 4'b1000, 1'b0, 1'b0, 3'd0, 4'b1000);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000);
    // bogus completions: non-active source, ID 0, out of range
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd4, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd7, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000);
    add(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd4, 4'b1000);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1000);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1000);
    // re-pend: edge while active, then complete
    add(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd1, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'b0001);
    // claim and edge in the same cycle
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd1, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'b0001);
    // complete and edge in the same cycle
    add(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 3'd1, 4'b0001);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001);
    // claim of one source together with completion of another
    add(4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0, 3'd0, 4'b0011, 1'b1, 1'b0, 3'd0, 4'b0011);
    add(4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 1'b1, 3'd1, 4'b0011);
    add(4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd1, 4'b0000, 1'b1, 1'b1, 3'd2, 4'b0011);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0011);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0011);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), pack(4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].src, vecs[i].wr, vecs[i].wdata, vecs[i].claim, vecs[i].cv, vecs[i].cid);
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].e_pend, vecs[i].e_irq, vecs[i].e_ack, vecs[i].e_id, vecs[i].e_mask));
    end

    // async reset with src 1 active and src 2 pending
    cyc(4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0, 3'd0);
    cyc(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    check("rst_setup_pend", {28'd0, pend}, 32'h6);
    cyc(4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0);
    check("rst_setup_claim", outs(), pack(4'b0100, 1'b1, 1'b1, 3'd2, 4'b0110));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clear", outs(), pack(4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000));
    src_irq = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0, 3'd0);
    check("post_rst_mask", outs(), pack(4'b0000, 1'b0, 1'b0, 3'd0, 4'b0110));
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
      check($sformatf("post_rst_quiet%0d", k), {27'd0, pend, irq_out}, 32'h0);
    end
    cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    check("post_rst_edge", {27'd0, pend, irq_out}, {27'd0, 4'b0100, 1'b0});
    cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    check("post_rst_irq", {31'd0, irq_out}, 32'd1);
    cyc(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0);
    check("post_rst_claim", {28'd0, claim_ack, claim_id}, {28'd0, 1'b1, 3'd3});

    // line already high at reset release fires once
    @(negedge clk);
    src_irq = 4'b0001;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    check("high_at_release", outs(), pack(4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000));
    cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0);
    check("high_held_no_irq", outs(), pack(4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
